uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver for the 8N1 serial link at 115200 baud from a 50 MHz clock.
//  Runs an internal bit-time counter and samples each bit at mid-period.
//  Shifts in 8 data bits LSB first, checks the stop bit and presents the byte
//  on dados_ascii with a one-cycle pronto pulse and a held tem_dado flag.
//  Sits between the serial RX pin and the command-decoding logic.
// PARAMETERS
//  M  434  clocks per bit (50M/115200); use 5208 for 9600 baud
//  N  9    width of the bit-time counter (N >= ceil(log2(M)); 13 for 5208)
// PORTS
//  clock           in   1  system clock, 50 MHz
//  reset           in   1  synchronous, active-high reset
//  entrada_serial  in   1  asynchronous RX line; idles high
//  recebe          in   1  consumer ack; clears tem_dado
//  dados_ascii     out  8  last correctly framed byte; held until the next good frame
//  pronto          out  1  1-cycle pulse when dados_ascii is updated
//  tem_dado        out  1  unread byte present
//  erro_quadro     out  1  framing error (stop bit = 0); sticky
//  sobrescrita     out  1  overrun: good byte arrived while tem_dado=1; sticky
//  db_tick         out  1  mid-bit sample strobe (debug)
//  db_estado       out  4  FSM state code (debug)
// BEHAVIOUR
//  - Reset values:
//    - Outputs: dados_ascii=0, all flags and pulses 0, db_estado=0.
//    - Internal: both synchronizer FFs=1; bit-time counter=0; bit index=0.
//  - Reset mid-frame aborts the frame; the line must be seen low again to start.
//  - Input sync: entrada_serial goes through 2 FFs to give rx_s. All logic uses rx_s.
//  - FSM (db_estado code):
//    - OCIOSO(0):
//      - rx_s=0 -> INICIO and zero the counter.
//    - INICIO(1):
//      - Counts M/2 cycles (integer division), then samples rx_s.
//      - rx_s=0 -> DADOS, zero the counter. rx_s=1 -> false start, back to OCIOSO.
//    - DADOS(2):
//      - Every M cycles: sample rx_s into shift[7], shift right, bit index +1.
//      - After the 8th sample -> PARADA.
//    - PARADA(3):
//      - After M cycles, sample rx_s.
//      - rx_s=1 -> ARMAZENA. rx_s=0 -> set erro_quadro, data discarded, go to ESPERA.
//    - ARMAZENA(4), single cycle:
//      - dados_ascii<=shift; pronto=1; tem_dado<=1; erro_quadro<=0.
//      - If tem_dado was already 1, set sobrescrita. Then -> OCIOSO.
//    - ESPERA(5):
//      - Stays until rx_s=1 (break/line-low guard), then -> OCIOSO.
//  - db_tick is high for exactly one cycle at each sample instant (start, 8 data, stop).
//  - Latency: if T0 is the first edge that registers entrada_serial=0, pronto is
//    high in cycle T0 + 2 + M/2 + 9*M + 1 (4126 at defaults).
//  - recebe=1 clears tem_dado and sobrescrita on the next edge.
//  - recebe in the same cycle as ARMAZENA: the new byte wins, tem_dado stays 1,
//    and sobrescrita is not set.
//  - Back-to-back frames: a start bit right after the stop sample is accepted.
//    OCIOSO is re-entered within 1 cycle of ARMAZENA.
//  - Counter wraps at M-1 -> 0; it never overflows N bits.
// TESTING
//  1. 8N1 byte 0x55 at M=434:
//     -> pronto 1 cycle at T0+4126; dados_ascii=0x55; tem_dado=1; erro_quadro=0.
//  2. Bytes 0x41 then 0x0A back-to-back, no ack:
//     -> dados_ascii=0x0A; sobrescrita=1.
//     -> recebe pulse -> tem_dado=0, sobrescrita=0.
//  3. Glitch: line low for 100 cycles, then high:
//     -> returns to OCIOSO; no pronto; db_estado never reaches 2.
//  4. Frame 0xC3 with stop bit 0, line held low 2000 cycles, then frame 0x31:
//     -> erro_quadro=1 and dados_ascii unchanged until 0x31 arrives.
//     -> FSM stays in 5 while low; 0x31 received; erro_quadro cleared.
//  5. reset pulse in the middle of DADOS for 0xFF, then a full 0x12 frame:
//     -> all outputs 0 after reset; 0x12 received correctly.
//  6. Sender clock +/-2% off nominal, bytes 0x00 and 0xFF:
//     -> both received correctly; db_tick count = 10 per frame.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling driven by
// an internal bit-time counter, framing/overrun flags and FSM debug taps.
module uart_rx #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe,
  output logic [7:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_quadro,
  output logic       sobrescrita,
  output logic       db_tick,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARADA   = 4'd3,
    ARMAZENA = 4'd4,
    ESPERA   = 4'd5
  } estado_t;

  localparam logic [N-1:0] HALF_LAST = N'(M / 2 - 1);
  localparam logic [N-1:0] FULL_LAST = N'(M - 1);

  // Handshake: pronto is a single-cycle strobe that coincides with new
  // dados_ascii; tem_dado stays high until the consumer pulses recebe.
  estado_t      r_state;
  estado_t      w_next;
  logic [1:0]   r_sync;
  logic [N-1:0] r_cnt;
  logic [2:0]   r_idx;
  logic [7:0]   r_shift;
  logic [7:0]   r_dados;
  logic         r_pronto;
  logic         r_tem;
  logic         r_erro;
  logic         r_sob;
  logic         w_rx_s;
  logic         w_tick;
  logic         w_cnt_clr;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clock) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], entrada_serial};
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= OCIOSO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tick    = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      OCIOSO: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) w_next = INICIO;
      end
      INICIO: begin
        if (r_cnt == HALF_LAST) begin
          w_tick    = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = w_rx_s ? OCIOSO : DADOS;
        end
      end
      DADOS: begin
        if (r_cnt == FULL_LAST) begin
          w_tick    = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_idx == 3'd7) w_next = PARADA;
        end
      end
      PARADA: begin
        if (r_cnt == FULL_LAST) begin
          w_tick    = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = w_rx_s ? ARMAZENA : ESPERA;
        end
      end
      ARMAZENA: begin
        w_cnt_clr = 1'b1;
        w_next    = OCIOSO;
      end
      ESPERA: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_next = OCIOSO;
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_next    = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || w_cnt_clr) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
    end else if (r_state == OCIOSO) begin
      r_idx <= 3'd0;
    end else if (r_state == DADOS && w_tick) begin
      r_shift <= {w_rx_s, r_shift[7:1]};
      r_idx   <= r_idx + 3'd1;
    end
  end

  // A store in the same cycle as recebe keeps the new byte flagged as unread.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dados  <= 8'd0;
      r_pronto <= 1'b0;
      r_tem    <= 1'b0;
      r_erro   <= 1'b0;
      r_sob    <= 1'b0;
    end else begin
      r_pronto <= (r_state == ARMAZENA);
      if (r_state == ARMAZENA) begin
        r_dados <= r_shift;
        r_tem   <= 1'b1;
        r_erro  <= 1'b0;
        if (r_tem && !recebe) r_sob <= 1'b1;
        else if (recebe)      r_sob <= 1'b0;
      end else begin
        if (recebe) begin
          r_tem <= 1'b0;
          r_sob <= 1'b0;
        end
        if (r_state == PARADA && w_tick && !w_rx_s) r_erro <= 1'b1;
      end
    end
  end

  assign dados_ascii = r_dados;
  assign pronto      = r_pronto;
  assign tem_dado    = r_tem;
  assign erro_quadro = r_erro;
  assign sobrescrita = r_sob;
  assign db_tick     = w_tick;
  assign db_estado   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven on the falling edge,
// outputs compared on the falling edge against hand-computed values.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       entrada_serial;
  logic       recebe;
  logic [7:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_quadro;
  logic       sobrescrita;
  logic       db_tick;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pronto = 0;
  int n_tick   = 0;
  int n_st2    = 0;
  int t_pronto = 0;
  int t_start  = 0;
  int p0, k0, s0;
  int found;

  uart_rx #(.M(434), .N(9)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .recebe         (recebe),
    .dados_ascii    (dados_ascii),
    .pronto         (pronto),
    .tem_dado       (tem_dado),
    .erro_quadro    (erro_quadro),
    .sobrescrita    (sobrescrita),
    .db_tick        (db_tick),
    .db_estado      (db_estado)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (pronto) begin
      n_pronto++;
      t_pronto = cyc;
    end
    if (db_tick) n_tick++;
    if (db_estado == 4'd2) n_st2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [7:0] d, input int p);
    entrada_serial = 1'b0;
    t_start = cyc + 1;
    idle(p);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = d[i];
      idle(p);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p);
    send_bits(d, p);
    entrada_serial = 1'b1;
    idle(p);
  endtask

  task automatic ack();
    recebe = 1'b1;
    @(negedge clock);
    recebe = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dados"},  {24'd0, dados_ascii}, 32'h00);
    check({tag, "_pronto"}, {31'd0, pronto},      32'd0);
    check({tag, "_tem"},    {31'd0, tem_dado},    32'd0);
    check({tag, "_erro"},   {31'd0, erro_quadro}, 32'd0);
    check({tag, "_sob"},    {31'd0, sobrescrita}, 32'd0);
    check({tag, "_tick"},   {31'd0, db_tick},     32'd0);
    check({tag, "_estado"}, {28'd0, db_estado},   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    entrada_serial = 1'b1;
    recebe = 1'b0;
    idle(3);
    check_cleared("reset");
    reset = 1'b0;
    idle(10);

    // 0x55 at nominal rate, exact pronto latency
    p0 = n_pronto; k0 = n_tick;
    send_frame(8'h55, 434);
    idle(5);
    check("t1_latency", t_pronto - t_start, 32'd4126);
    check("t1_pronto_cnt", n_pronto - p0, 32'd1);
    check("t1_dados", {24'd0, dados_ascii}, 32'h55);
    check("t1_tem", {31'd0, tem_dado}, 32'd1);
    check("t1_erro", {31'd0, erro_quadro}, 32'd0);
    check("t1_ticks", n_tick - k0, 32'd10);
    ack();
    check("t1_ack_tem", {31'd0, tem_dado}, 32'd0);

    // back-to-back without ack -> overrun
    p0 = n_pronto;
    send_frame(8'h41, 434);
    send_frame(8'h0A, 434);
    idle(5);
    check("t2_pronto_cnt", n_pronto - p0, 32'd2);
    check("t2_dados", {24'd0, dados_ascii}, 32'h0A);
    check("t2_sob", {31'd0, sobrescrita}, 32'd1);
    check("t2_tem", {31'd0, tem_dado}, 32'd1);
    ack();
    check("t2_ack_tem", {31'd0, tem_dado}, 32'd0);
    check("t2_ack_sob", {31'd0, sobrescrita}, 32'd0);

    // short glitch is a false start
    p0 = n_pronto; s0 = n_st2;
    entrada_serial = 1'b0;
    idle(100);
    entrada_serial = 1'b1;
    idle(600);
    check("t3_estado", {28'd0, db_estado}, 32'd0);
    check("t3_no_pronto", n_pronto - p0, 32'd0);
    check("t3_no_dados_state", n_st2 - s0, 32'd0);

    // framing error, line held low, then a good frame
    p0 = n_pronto;
    send_bits(8'hC3, 434);
    entrada_serial = 1'b0;
    idle(1500);
    check("t4_estado_espera", {28'd0, db_estado}, 32'd5);
    check("t4_erro", {31'd0, erro_quadro}, 32'd1);
    check("t4_dados_kept", {24'd0, dados_ascii}, 32'h0A);
    check("t4_no_pronto", n_pronto - p0, 32'd0);
    idle(500);
    check("t4_still_espera", {28'd0, db_estado}, 32'd5);
    entrada_serial = 1'b1;
    idle(20);
    check("t4_back_ocioso", {28'd0, db_estado}, 32'd0);
    check("t4_erro_sticky", {31'd0, erro_quadro}, 32'd1);
    send_frame(8'h31, 434);
    idle(5);
    check("t4_dados", {24'd0, dados_ascii}, 32'h31);
    check("t4_erro_clr", {31'd0, erro_quadro}, 32'd0);
    check("t4_tem", {31'd0, tem_dado}, 32'd1);
    ack();

    // reset in the middle of a 0xFF frame
    entrada_serial = 1'b0;
    idle(434);
    entrada_serial = 1'b1;
    idle(2 * 434 + 100);
    check("t5_in_dados", {28'd0, db_estado}, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_cleared("t5_reset");
    idle(7 * 434);
    check("t5_idle", {28'd0, db_estado}, 32'd0);
    send_frame(8'h12, 434);
    idle(5);
    check("t5_dados", {24'd0, dados_ascii}, 32'h12);
    check("t5_tem", {31'd0, tem_dado}, 32'd1);
    ack();

    // sender rate +2% slow and -2% fast
    k0 = n_tick;
    send_frame(8'h00, 443);
    idle(5);
    check("t6_slow_dados", {24'd0, dados_ascii}, 32'h00);
    check("t6_slow_ticks", n_tick - k0, 32'd10);
    check("t6_slow_erro", {31'd0, erro_quadro}, 32'd0);
    ack();
    k0 = n_tick;
    send_frame(8'hFF, 425);
    idle(5);
    check("t6_fast_dados", {24'd0, dados_ascii}, 32'hFF);
    check("t6_fast_ticks", n_tick - k0, 32'd10);
    check("t6_fast_erro", {31'd0, erro_quadro}, 32'd0);
    ack();

    // recebe coinciding with the store cycle
    send_frame(8'h5A, 434);
    idle(5);
    check("t7_first_tem", {31'd0, tem_dado}, 32'd1);
    found = 0;
    fork
      send_frame(8'hA5, 434);
      begin
        for (int i = 0; i < 5000 && found == 0; i++) begin
          @(negedge clock);
          if (db_estado == 4'd4) begin
            recebe = 1'b1;
            found = 1;
          end
        end
        if (found != 0) begin
          @(negedge clock);
          recebe = 1'b0;
        end
      end
    join
    idle(5);
    check("t7_store_seen", found, 32'd1);
    check("t7_dados", {24'd0, dados_ascii}, 32'hA5);
    check("t7_tem", {31'd0, tem_dado}, 32'd1);
    check("t7_sob", {31'd0, sobrescrita}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
